// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: three read ports, two write ports, scoreboard issue port.
interface reg_file_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned ADDR_W   = 4
);
  logic [ADDR_W-1:0]   rd_addr0, rd_addr1, rd_addr2;
  logic [DATA_W-1:0]   rd_data0, rd_data1, rd_data2;
  logic                rd_busy0, rd_busy1, rd_busy2;
  logic                wr_en_a;
  logic [ADDR_W-1:0]   wr_addr_a;
  logic [DATA_W-1:0]   wr_data_a;
  logic                wr_en_b;
  logic [ADDR_W-1:0]   wr_addr_b;
  logic [DATA_W-1:0]   wr_data_b;
  logic                busy_set_en;
  logic [ADDR_W-1:0]   busy_set_addr;
  logic [NUM_REGS-1:0] busy_vec;
  logic                wr_conflict;

  modport master (
    output rd_addr0, rd_addr1, rd_addr2,
    input  rd_data0, rd_data1, rd_data2,
    input  rd_busy0, rd_busy1, rd_busy2,
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    output busy_set_en, busy_set_addr,
    input  busy_vec, wr_conflict
  );

  modport slave (
    input  rd_addr0, rd_addr1, rd_addr2,
    output rd_data0, rd_data1, rd_data2,
    output rd_busy0, rd_busy1, rd_busy2,
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    input  busy_set_en, busy_set_addr,
    output busy_vec, wr_conflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port architectural register file (R0..R14) with write bypass and
// a per-register pending scoreboard for the hazard unit.
module reg_file_mp #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 15,
  parameter int unsigned ADDR_W      = 4,
  parameter bit          RESET_INDEX = 1'b1
) (
  input logic         clk,
  input logic         rst,
  reg_file_mp_if.slave bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                conflict_q;

  logic                a_ok, b_ok, b_write, conflict_d;
  logic [ADDR_W-1:0]   rd_addr [3];
  logic [DATA_W-1:0]   rd_data [3];
  logic                rd_busy [3];

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < NUM_REGS;
  endfunction

  // Write qualification: A wins a same-address collision, B is dropped
  always_comb begin
    a_ok       = bus.wr_en_a && in_range(bus.wr_addr_a);
    b_ok       = bus.wr_en_b && in_range(bus.wr_addr_b);
    conflict_d = a_ok && b_ok && (bus.wr_addr_a == bus.wr_addr_b);
    b_write    = b_ok && !conflict_d;
  end

  // Scoreboard next state: a new issue supersedes a completing writeback
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.busy_set_en && 32'(bus.busy_set_addr) == i)
        busy_d[i] = 1'b1;
      else if ((a_ok && 32'(bus.wr_addr_a) == i) || (b_ok && 32'(bus.wr_addr_b) == i))
        busy_d[i] = 1'b0;
    end
  end

  // Read ports: bypass A, then B, then array; busy released by a same-cycle writeback
  always_comb begin
    rd_addr[0] = bus.rd_addr0;
    rd_addr[1] = bus.rd_addr1;
    rd_addr[2] = bus.rd_addr2;
    for (int unsigned p = 0; p < 3; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (in_range(rd_addr[p])) begin
        if (a_ok && bus.wr_addr_a == rd_addr[p])
          rd_data[p] = bus.wr_data_a;
        else if (b_ok && bus.wr_addr_b == rd_addr[p])
          rd_data[p] = bus.wr_data_b;
        else
          rd_data[p] = regs[rd_addr[p]];
        rd_busy[p] = busy_q[rd_addr[p]]
                     && !(a_ok && bus.wr_addr_a == rd_addr[p])
                     && !(b_ok && bus.wr_addr_b == rd_addr[p]);
      end
    end
  end

  // Register array, scoreboard and conflict flag; reset overrides all updates
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_INDEX ? DATA_W'(i) : '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (a_ok)
        regs[bus.wr_addr_a] <= bus.wr_data_a;
      if (b_write)
        regs[bus.wr_addr_b] <= bus.wr_data_b;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.rd_data0    = rd_data[0];
  assign bus.rd_data1    = rd_data[1];
  assign bus.rd_data2    = rd_data[2];
  assign bus.rd_busy0    = rd_busy[0];
  assign bus.rd_busy1    = rd_busy[1];
  assign bus.rd_busy2    = rd_busy[2];
  assign bus.busy_vec    = busy_q;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed, table-driven bench for reg_file_mp (DATA_W=32, NUM_REGS=15, RESET_INDEX=1).
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(32), .NUM_REGS(15), .ADDR_W(4)) bus ();

  reg_file_mp #(.DATA_W(32), .NUM_REGS(15), .ADDR_W(4), .RESET_INDEX(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wa;
    logic [3:0]  aa;
    logic [31:0] da;
    logic        wb;
    logic [3:0]  ab;
    logic [31:0] db;
    logic        bs;
    logic [3:0]  bsa;
    logic [3:0]  r0, r1, r2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  ebusy;   // {port2, port1, port0}, before the edge
    logic [14:0] ebv;     // busy_vec after the edge
    logic        econf;   // wr_conflict after the edge
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en_a = 1'b0; bus.wr_addr_a = 4'd0; bus.wr_data_a = 32'h0;
    bus.wr_en_b = 1'b0; bus.wr_addr_b = 4'd0; bus.wr_data_b = 32'h0;
    bus.busy_set_en = 1'b0; bus.busy_set_addr = 4'd0;
  endtask

  initial begin
    //        wa    aa     da             wb    ab     db             bs    bsa    r0     r1     r2     e0             e1             e2             ebusy   ebv        econf
    vecs[0]  = '{1'b1, 4'd5,  32'h12345678, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd5,  4'd6,  4'd15, 32'h12345678, 32'd6,         32'h0,         3'b000, 15'h0000, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd5,  4'd0,  4'd14, 32'h12345678, 32'd0,         32'd14,        3'b000, 15'h0000, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd5,  32'hCAFEF00D, 1'b0, 4'd0,  4'd1,  4'd2,  4'd5,  32'd1,         32'd2,         32'hCAFEF00D, 3'b000, 15'h0000, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd5,  4'd7,  4'd8,  32'hCAFEF00D, 32'd7,         32'd8,         3'b000, 15'h0000, 1'b0};
    vecs[4]  = '{1'b1, 4'd7,  32'hAAAA,     1'b1, 4'd7,  32'hBBBB,     1'b0, 4'd0,  4'd7,  4'd7,  4'd8,  32'hAAAA,     32'hAAAA,      32'd8,         3'b000, 15'h0000, 1'b1};
    vecs[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd7,  4'd8,  4'd0,  32'hAAAA,     32'd8,         32'd0,         3'b000, 15'h0000, 1'b0};
    vecs[6]  = '{1'b1, 4'd1,  32'h11,       1'b1, 4'd2,  32'h22,       1'b0, 4'd0,  4'd1,  4'd2,  4'd3,  32'h11,       32'h22,        32'd3,         3'b000, 15'h0000, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd4,  4'd4,  4'd3,  4'd4,  32'd4,         32'd3,         32'd4,         3'b000, 15'h0010, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd4,  4'd3,  4'd4,  32'd4,         32'd3,         32'd4,         3'b101, 15'h0010, 1'b0};
    vecs[9]  = '{1'b1, 4'd4,  32'h44,       1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd4,  4'd5,  4'd4,  32'h44,       32'hCAFEF00D,  32'h44,        3'b000, 15'h0000, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd2,  32'h2222,     1'b1, 4'd2,  4'd2,  4'd4,  4'd0,  32'h2222,     32'h44,        32'd0,         3'b000, 15'h0004, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd2,  4'd2,  4'd1,  32'h2222,     32'h2222,      32'h11,        3'b011, 15'h0004, 1'b0};
    vecs[12] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd2,  4'd2,  4'd0,  4'd0,  32'h2222,     32'd0,         32'd0,         3'b001, 15'h0004, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd2,  32'h3333,     1'b1, 4'd6,  4'd2,  4'd6,  4'd2,  32'h3333,     32'd6,         32'h3333,      3'b000, 15'h0040, 1'b0};
    vecs[14] = '{1'b1, 4'd10, 32'hA0,       1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd6,  4'd10, 4'd9,  32'd6,         32'hA0,        32'd9,         3'b001, 15'h0040, 1'b0};
    vecs[15] = '{1'b1, 4'd15, 32'hFFFF,     1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 4'd15, 4'd14, 4'd6,  32'd0,         32'd14,        32'd6,         3'b100, 15'h0040, 1'b0};
    vecs[16] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd15, 4'd14, 4'd10, 32'd0,         32'd14,        32'hA0,        3'b000, 15'h0040, 1'b0};

    // Reset while a write is requested: the write must be discarded
    idle_inputs();
    bus.rd_addr0 = 4'd0; bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd0;
    rst = 1'b1;
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 4'd3; bus.wr_data_a = 32'hDEAD;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    bus.rd_addr0 = 4'd3; bus.rd_addr1 = 4'd14; bus.rd_addr2 = 4'd15;
    #1;
    check("reset_r3", bus.rd_data0, 32'd3);
    check("reset_r14", bus.rd_data1, 32'd14);
    check("reset_oor", bus.rd_data2, 32'd0);
    check("reset_busy", {29'd0, bus.rd_busy2, bus.rd_busy1, bus.rd_busy0}, 32'd0);
    check("reset_busy_vec", {17'd0, bus.busy_vec}, 32'd0);
    check("reset_conflict", {31'd0, bus.wr_conflict}, 32'd0);

    // Table: apply, check combinational reads before the edge, check registered outputs after
    for (int i = 0; i < 17; i++) begin
      bus.wr_en_a = vecs[i].wa; bus.wr_addr_a = vecs[i].aa; bus.wr_data_a = vecs[i].da;
      bus.wr_en_b = vecs[i].wb; bus.wr_addr_b = vecs[i].ab; bus.wr_data_b = vecs[i].db;
      bus.busy_set_en = vecs[i].bs; bus.busy_set_addr = vecs[i].bsa;
      bus.rd_addr0 = vecs[i].r0; bus.rd_addr1 = vecs[i].r1; bus.rd_addr2 = vecs[i].r2;
      #1;
      check($sformatf("v%0d_rd0", i), bus.rd_data0, vecs[i].e0);
      check($sformatf("v%0d_rd1", i), bus.rd_data1, vecs[i].e1);
      check($sformatf("v%0d_rd2", i), bus.rd_data2, vecs[i].e2);
      check($sformatf("v%0d_busy", i), {29'd0, bus.rd_busy2, bus.rd_busy1, bus.rd_busy0},
            {29'd0, vecs[i].ebusy});
      @(posedge clk); #1;
      idle_inputs();
      check($sformatf("v%0d_busy_vec", i), {17'd0, bus.busy_vec}, {17'd0, vecs[i].ebv});
      check($sformatf("v%0d_conflict", i), {31'd0, bus.wr_conflict}, {31'd0, vecs[i].econf});
    end

    // Collision then reset on the very next edge: conflict pulse and scoreboard cleared
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 4'd8; bus.wr_data_a = 32'h8A;
    bus.wr_en_b = 1'b1; bus.wr_addr_b = 4'd8; bus.wr_data_b = 32'h8B;
    bus.busy_set_en = 1'b1; bus.busy_set_addr = 4'd9;
    @(posedge clk); #1;
    check("pre_rst_conflict", {31'd0, bus.wr_conflict}, 32'd1);
    check("pre_rst_busy_vec", {17'd0, bus.busy_vec}, 32'h0240);
    idle_inputs();
    rst = 1'b1;
    bus.busy_set_en = 1'b1; bus.busy_set_addr = 4'd3;
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 4'd5; bus.wr_data_a = 32'h1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    bus.rd_addr0 = 4'd5; bus.rd_addr1 = 4'd9; bus.rd_addr2 = 4'd8;
    #1;
    check("mid_rst_busy_vec", {17'd0, bus.busy_vec}, 32'd0);
    check("mid_rst_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    check("mid_rst_r5", bus.rd_data0, 32'd5);
    check("mid_rst_r8", bus.rd_data2, 32'd8);
    check("mid_rst_busy_r9", {31'd0, bus.rd_busy1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
